set_bit_walker: RTL

//   Sequential consumer of the find-next-set-bit function. Accepts a W-bit word

---
 rtl/set_bit_walker_pkg.sv | 22 ++
 rtl/set_bit_walker_fns_core.sv | 52 +++++
 rtl/set_bit_walker.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/set_bit_walker_pkg.sv
// ---------------------------------------------------------------------------
// set_bit_walker_pkg
//   Shared types and helpers for the set-bit walker.
//   - state_t : walker FSM states (idle / walking a word)
//   - inc_mod : increment modulo a power-of-two width
// ---------------------------------------------------------------------------
package set_bit_walker_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WALK = 1'b1
  } state_t;

  // Increment v by one and wrap at w. w must be a power of two, so the
  // wrap is a simple mask rather than a compare.
  function automatic logic [31:0] inc_mod(input logic [31:0] v, input logic [31:0] w);
    logic [31:0] r;
    r = (v + 32'd1) & (w - 32'd1);
    return r;
  endfunction

endpackage

// File: rtl/set_bit_walker_fns_core.sv
// ---------------------------------------------------------------------------
// fns_core
//   Combinational find-next-set-bit, circular, starting at pos_i (inclusive).
//   Ports:
//     x_i     [W]      word to search
//     pos_i   [IW]     start position
//     any_o            1 when x_i has at least one set bit
//     y_o     [W]      one-hot of the first set bit found (0 if none)
//     y_enc_o [IW]     binary index of y_o (0 if none)
// ---------------------------------------------------------------------------
module fns_core #(
  parameter int W = 32
) (
  input  logic [W-1:0]         x_i,
  input  logic [$clog2(W)-1:0] pos_i,
  output logic                 any_o,
  output logic [W-1:0]         y_o,
  output logic [$clog2(W)-1:0] y_enc_o
);

  localparam int IW = $clog2(W);
  localparam int DW = 2 * W;

  logic [W-1:0]  lo_mask_s;
  logic [DW-1:0] dbl_s;
  logic [DW-1:0] iso_s;

  // Double-width search: the low half keeps only bits at or above pos_i,
  // the high half is the full word and supplies the wrapped-around bits.
  // Isolating the lowest set bit of the concatenation gives the circular
  // first hit; folding both halves together yields the one-hot result.
  always_comb begin
    lo_mask_s = ~((W'(1) << pos_i) - W'(1));
    dbl_s     = {x_i, x_i & lo_mask_s};
    iso_s     = dbl_s & (~dbl_s + DW'(1));
    y_o       = iso_s[W-1:0] | iso_s[DW-1:W];
    any_o     = |x_i;
  end

  // One-hot to binary encode by OR-ing the index of the single set bit.
  always_comb begin
    y_enc_o = {IW{1'b0}};
    for (int i = 0; i < W; i++) begin
      if (y_o[i]) begin
        y_enc_o = y_enc_o | IW'(i);
      end else begin
        y_enc_o = y_enc_o;
      end
    end
  end

endmodule

// File: rtl/set_bit_walker.sv
// ---------------------------------------------------------------------------
// set_bit_walker
//   Accepts a W-bit word plus a start position and emits the index of each
//   set bit, one per beat, in circular order from the start position. A zero
//   word produces a single beat with out_any_o=0. Valid/ready on both sides;
//   a new word may be accepted on the same edge the last beat is taken.
//   Ports:
//     clk, arst_n            clock, async active-low reset
//     in_vld_i / in_rdy_o    input handshake
//     in_x_i  [W]            word to walk
//     in_pos_i [IW]          start position (inclusive)
//     out_vld_o / out_rdy_i  output handshake
//     out_any_o              beat carries a set bit
//     out_idx_o [IW]         index of current set bit
//     out_onehot_o [W]       one-hot of out_idx_o
//     out_last_o             final beat of the current word
// ---------------------------------------------------------------------------
module set_bit_walker
  import set_bit_walker_pkg::*;
#(
  parameter int W = 32
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 in_vld_i,
  output logic                 in_rdy_o,
  input  logic [W-1:0]         in_x_i,
  input  logic [$clog2(W)-1:0] in_pos_i,
  output logic                 out_vld_o,
  input  logic                 out_rdy_i,
  output logic                 out_any_o,
  output logic [$clog2(W)-1:0] out_idx_o,
  output logic [W-1:0]         out_onehot_o,
  output logic                 out_last_o
);

  localparam int IW = $clog2(W);

  state_t        st_q, st_d;
  logic [W-1:0]  mask_q, mask_d;
  logic [IW-1:0] pos_q, pos_d;
  logic          zero_q, zero_d;

  logic          core_any_s;
  logic [W-1:0]  core_y_s;
  logic [IW-1:0] core_enc_s;
  logic          walk_s;
  logic          last_s;
  logic          take_s;
  logic          accept_s;

  fns_core #(.W(W)) u_fns (
    .x_i     (mask_q),
    .pos_i   (pos_q),
    .any_o   (core_any_s),
    .y_o     (core_y_s),
    .y_enc_o (core_enc_s)
  );

  // State and walk registers.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      st_q   <= ST_IDLE;
      mask_q <= {W{1'b0}};
      pos_q  <= {IW{1'b0}};
      zero_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      mask_q <= mask_d;
      pos_q  <= pos_d;
      zero_q <= zero_d;
    end
  end

  // Handshake terms. A zero word yields y=0, so the "remaining mask empty"
  // test is already true for it; zero_q is kept explicit for clarity.
  always_comb begin
    walk_s   = (st_q == ST_WALK);
    last_s   = zero_q | ((mask_q & ~core_y_s) == {W{1'b0}});
    take_s   = walk_s & out_rdy_i;
    accept_s = in_vld_i & in_rdy_o;
  end

  // Next-state: retire the current bit on a taken beat, then let an accepted
  // word override so the last beat and the next word share one edge.
  always_comb begin
    st_d   = st_q;
    mask_d = mask_q;
    pos_d  = pos_q;
    zero_d = zero_q;
    case (st_q)
      ST_IDLE: begin
        st_d = ST_IDLE;
      end
      ST_WALK: begin
        if (take_s) begin
          mask_d = mask_q & ~core_y_s;
          pos_d  = IW'(inc_mod(32'(core_enc_s), 32'(W)));
          if (last_s) begin
            st_d = ST_IDLE;
          end else begin
            st_d = ST_WALK;
          end
        end else begin
          st_d = ST_WALK;
        end
      end
      default: begin
        st_d = ST_IDLE;
      end
    endcase
    if (accept_s) begin
      mask_d = in_x_i;
      pos_d  = in_pos_i;
      zero_d = (in_x_i == {W{1'b0}});
      st_d   = ST_WALK;
    end else begin
      zero_d = zero_d;
    end
  end

  // Outputs: live only while walking, forced to zero otherwise.
  always_comb begin
    in_rdy_o = (st_q == ST_IDLE) | (take_s & last_s);
    if (walk_s) begin
      out_vld_o    = 1'b1;
      out_any_o    = !zero_q & core_any_s;
      out_idx_o    = core_enc_s;
      out_onehot_o = core_y_s;
      out_last_o   = last_s;
    end else begin
      out_vld_o    = 1'b0;
      out_any_o    = 1'b0;
      out_idx_o    = {IW{1'b0}};
      out_onehot_o = {W{1'b0}};
      out_last_o   = 1'b0;
    end
  end

endmodule
